fx3_transfer_controller: RTL and testbench

Sequences packet transfers from the ADC sample FIFO to the FX3 GPIF slave FIFO interface, all in the fx3_clock domain. Waits until a full packet is buffered and FX3 is ready, then issues a fixed-length burst of FIFO read requests. Each read is matched by an FX3 write strobe, delayed to line up with the registered sample-conversion datapath. Aborts cleanly on a buffer error and reports packet and abort status.

---
 rtl/fx3_transfer_controller.sv | 207 ++++++++++++++++++++
 tb/tb_fx3_transfer_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_transfer_controller.sv
// rtl/fx3_transfer_controller.sv - ADC sample FIFO to FX3 slave FIFO packet sequencer
//
// Purpose:
//   Waits until a full packet is buffered in the sample FIFO and the FX3 DMA
//   watermark says a packet fits. It then issues a contiguous burst of
//   PACKET_WORDS FIFO read requests. Each read is echoed as an FX3 write strobe
//   READ_LATENCY cycles later, so the strobe lines up with the registered
//   10-to-16 sample conversion. A buffer error mid-burst stops the reads. The
//   pipeline is then drained and the short packet is committed with a single
//   pktend strobe. The controller then parks in HALT until capture is disabled.
//
// Parameters:
//   PACKET_WORDS  16-bit words per USB packet (2..32768)
//   READ_LATENCY  cycles from readData to the word on the FX3 bus (>= 1)
//   GAP_CYCLES    idle cycles after each packet for FX3 flag update (>= 1)
//
// Ports:
//   fx3_clock      in   only clock
//   nReset         in   asynchronous active-low reset
//   collectData    in   capture enable
//   dataAvailable  in   FIFO holds at least PACKET_WORDS words
//   bufferError    in   FIFO overflow / near-full error
//   fx3_ready      in   FX3 watermark, a full packet can be accepted
//   readData       out  FIFO read request
//   fx3_wr_n       out  slave FIFO write strobe, active low
//   fx3_pktend_n   out  packet-end strobe, active low
//   busy           out  controller is not in IDLE
//   abortFlag      out  sticky abort indicator, cleared when capture stops
//   packetCount    out  completed packets, wraps modulo 65536
//
// Build option:
//   PACKET_COUNT_EN  when defined, packetCount counts completed packets;
//                    otherwise packetCount is tied to zero.

module fx3_transfer_controller #(
  parameter int PACKET_WORDS = 8192,
  parameter int READ_LATENCY = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        fx3_clock,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic        bufferError,
  input  logic        fx3_ready,
  output logic        readData,
  output logic        fx3_wr_n,
  output logic        fx3_pktend_n,
  output logic        busy,
  output logic        abortFlag,
  output logic [15:0] packetCount
);

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    DRAIN,
    ABORT_DRAIN,
    HALT,
    GAP
  } stateType;

  // One shared delay counter serves DRAIN, ABORT_DRAIN and GAP, so it must
  // reach the largest terminal value of the three.
  localparam int DELAY_MAX = (READ_LATENCY > GAP_CYCLES) ? READ_LATENCY : GAP_CYCLES;
  localparam int DELAY_W   = $clog2(DELAY_MAX + 1);

  localparam logic [15:0]        LAST_WORD  = 16'(PACKET_WORDS - 1);
  localparam logic [DELAY_W-1:0] DRAIN_LAST = DELAY_W'(READ_LATENCY - 1);
  // The abort wait runs one cycle longer than the normal drain. This way
  // pktend never shares a cycle with, or directly follows, the final write strobe.
  localparam logic [DELAY_W-1:0] ABORT_LAST = DELAY_W'(READ_LATENCY);
  localparam logic [DELAY_W-1:0] GAP_LAST   = DELAY_W'(GAP_CYCLES - 1);

  stateType               state;
  logic [15:0]            wordCount;
  logic [DELAY_W-1:0]     delayCount;
  logic [READ_LATENCY-1:0] readPipe;
  logic                   startRequest;

  assign startRequest = collectData & dataAvailable & fx3_ready;

  // Write strobe is the read request delayed through the datapath latency.
  // Writes therefore match reads one for one, in count and order.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      readPipe <= '0;
    end else begin
      readPipe[0] <= readData;
      for (int i = 1; i < READ_LATENCY; i++) begin
        readPipe[i] <= readPipe[i-1];
      end
    end
  end

  assign fx3_wr_n = ~readPipe[READ_LATENCY-1];

  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      wordCount    <= '0;
      delayCount   <= '0;
      readData     <= 1'b0;
      fx3_pktend_n <= 1'b1;
      busy         <= 1'b0;
      abortFlag    <= 1'b0;
    end else begin
      // pktend is a one-cycle strobe; it is raised again on every edge.
      fx3_pktend_n <= 1'b1;

      case (state)
        IDLE: begin
          if (startRequest) begin
            busy <= 1'b1;
            if (bufferError) begin
              // Nothing has been read yet, so there is no short packet to commit.
              abortFlag <= 1'b1;
              state     <= HALT;
            end else begin
              readData  <= 1'b1;
              wordCount <= '0;
              state     <= BURST;
            end
          end
        end

        BURST: begin
          // The last-word test comes first. An error on the final read
          // still yields a complete packet.
          if (wordCount == LAST_WORD) begin
            readData   <= 1'b0;
            delayCount <= '0;
            state      <= DRAIN;
          end else if (bufferError) begin
            readData   <= 1'b0;
            wordCount  <= wordCount + 16'd1;
            delayCount <= '0;
            state      <= ABORT_DRAIN;
          end else begin
            wordCount <= wordCount + 16'd1;
          end
        end

        DRAIN: begin
          if (delayCount == DRAIN_LAST) begin
            delayCount <= '0;
            state      <= GAP;
          end else begin
            delayCount <= delayCount + DELAY_W'(1);
          end
        end

        ABORT_DRAIN: begin
          if (delayCount == ABORT_LAST) begin
            fx3_pktend_n <= 1'b0;
            abortFlag    <= 1'b1;
            state        <= HALT;
          end else begin
            delayCount <= delayCount + DELAY_W'(1);
          end
        end

        HALT: begin
          if (!collectData) begin
            abortFlag <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        GAP: begin
          if (delayCount == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            delayCount <= delayCount + DELAY_W'(1);
          end
        end

        default: begin
          readData <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef PACKET_COUNT_EN
  logic drainDone;

  // A packet counts as complete on the final drain cycle, the cycle in which
  // its last write strobe is on the bus.
  assign drainDone = (state == DRAIN) && (delayCount == DRAIN_LAST);

  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      packetCount <= '0;
    end else if (drainDone) begin
      packetCount <= packetCount + 16'd1;
    end
  end
`else
  assign packetCount = 16'd0;
`endif

endmodule

// File: tb/tb_fx3_transfer_controller.sv
// tb/tb_fx3_transfer_controller.sv - randomized self-checking bench for fx3_transfer_controller
`timescale 1ns/1ps

module tb_fx3_transfer_controller;

  localparam int PW  = 8192;
  localparam int LAT = 2;
  localparam int GAP = 4;

  logic        fx3_clock = 1'b0;
  logic        nReset = 1'b0;
  logic        collectData = 1'b0;
  logic        dataAvailable = 1'b0;
  logic        bufferError = 1'b0;
  logic        fx3_ready = 1'b0;
  logic        readData;
  logic        fx3_wr_n;
  logic        fx3_pktend_n;
  logic        busy;
  logic        abortFlag;
  logic [15:0] packetCount;

  fx3_transfer_controller #(
    .PACKET_WORDS(PW),
    .READ_LATENCY(LAT),
    .GAP_CYCLES  (GAP)
  ) dut (
    .fx3_clock    (fx3_clock),
    .nReset       (nReset),
    .collectData  (collectData),
    .dataAvailable(dataAvailable),
    .bufferError  (bufferError),
    .fx3_ready    (fx3_ready),
    .readData     (readData),
    .fx3_wr_n     (fx3_wr_n),
    .fx3_pktend_n (fx3_pktend_n),
    .busy         (busy),
    .abortFlag    (abortFlag),
    .packetCount  (packetCount)
  );

  always #5 fx3_clock = ~fx3_clock;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int expPackets = 0;
  int readLog[$];
  int writeLog[$];
  int pktendLog[$];

  // Strobe log, sampled mid-cycle: the cycle index of every read, write and pktend.
  always @(negedge fx3_clock) begin
    cycle = cycle + 1;
    if (readData)      readLog.push_back(cycle);
    if (!fx3_wr_n)     writeLog.push_back(cycle);
    if (!fx3_pktend_n) pktendLog.push_back(cycle);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic checkValue(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int expectedCount();
`ifdef PACKET_COUNT_EN
    return expPackets % 65536;
`else
    return 0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge fx3_clock);
      #1;
    end
  endtask

  task automatic clearLog();
    readLog.delete();
    writeLog.delete();
    pktendLog.delete();
  endtask

  // Returns one cycle after the n-th read was seen, that is, during read n+1 if one exists.
  task automatic waitReads(input string tag, input int n, input int budget);
    int k = 0;
    while (readLog.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checkValue({tag, ".reachReads"}, int'(readLog.size() >= n), 1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    checkValue({tag, ".idle"}, busy, 0);
  endtask

  // Reference rules: read total, contiguous runs, and each write exactly LAT after its read.
  task automatic checkLog(input string tag, input int nReads, input int nBreaks, input int nPkt);
    int breaks = 0;
    int skew = 0;
    for (int i = 1; i < readLog.size(); i++)
      if (readLog[i] != readLog[i-1] + 1) breaks++;
    for (int i = 0; i < writeLog.size() && i < readLog.size(); i++)
      if (writeLog[i] != readLog[i] + LAT) skew++;
    checkValue({tag, ".reads"},  readLog.size(),   nReads);
    checkValue({tag, ".writes"}, writeLog.size(),  nReads);
    checkValue({tag, ".breaks"}, breaks,           nBreaks);
    checkValue({tag, ".wrSkew"}, skew,             0);
    checkValue({tag, ".pktend"}, pktendLog.size(), nPkt);
  endtask

  task automatic runAbort(input int n);
    int pktDelta;
    clearLog();
    collectData = 1'b1; dataAvailable = 1'b1; fx3_ready = 1'b1; bufferError = 1'b0;
    waitReads("abort", n - 1, n + 50);
    bufferError = 1'b1;
    tick(1);
    bufferError = 1'b0;
    tick(20);
    checkLog("abort", n, 0, 1);
    pktDelta = -1;
    if (pktendLog.size() == 1 && writeLog.size() == n) pktDelta = pktendLog[0] - writeLog[n-1];
    checkValue("abort.pktendDelay", pktDelta, 2);
    checkValue("abort.flag", abortFlag, 1);
    checkValue("abort.busy", busy, 1);
    checkValue("abort.packetCount", packetCount, expectedCount());
    collectData = 1'b0;
    tick(3);
    checkValue("abort.flagCleared", abortFlag, 0);
    checkValue("abort.idle", busy, 0);
    checkValue("abort.noMoreReads", readLog.size(), n);
    dataAvailable = 1'b0;
  endtask

  initial begin
    int startCycle;
    int delta;
    int v;

    // Reset state
    tick(3);
    checkValue("rst.readData", readData, 0);
    checkValue("rst.wr_n", fx3_wr_n, 1);
    checkValue("rst.pktend_n", fx3_pktend_n, 1);
    checkValue("rst.busy", busy, 0);
    checkValue("rst.abortFlag", abortFlag, 0);
    checkValue("rst.packetCount", packetCount, 0);
    nReset = 1'b1;
    tick(2);

    // Start gating: random input mixes where the three start inputs are never all high
    clearLog();
    for (int i = 0; i < 10; i++) begin
      v = $urandom_range(0, 15);
      if ((v & 7) == 7) v = v & ~(1 << $urandom_range(0, 2));
      collectData = v[0]; dataAvailable = v[1]; fx3_ready = v[2]; bufferError = v[3];
      tick($urandom_range(1, 4));
    end
    collectData = 1'b0; dataAvailable = 1'b0; fx3_ready = 1'b0; bufferError = 1'b0;
    tick(2);
    checkValue("gate.reads", readLog.size(), 0);
    checkValue("gate.busy", busy, 0);
    checkValue("gate.abortFlag", abortFlag, 0);

    // Two back-to-back packets with the start inputs held high
    clearLog();
    startCycle = cycle;
    collectData = 1'b1; dataAvailable = 1'b1; fx3_ready = 1'b1;
    waitReads("b2b1", PW, PW + 100);
    tick(3);
    expPackets++;
    checkValue("b2b.firstPacketCount", packetCount, expectedCount());
    waitReads("b2b2", 2 * PW, PW + 100);
    dataAvailable = 1'b0;
    waitIdle("b2b", 100);
    tick(10);
    expPackets++;
    checkLog("b2b", 2 * PW, 1, 0);
    delta = -1;
    if (readLog.size() > 0) delta = readLog[0] - startCycle;
    checkValue("b2b.startLatency", delta, 2);
    delta = -1;
    if (readLog.size() > PW) delta = readLog[PW] - readLog[PW-1];
    checkValue("b2b.interPacket", delta, LAT + GAP + 2);
    checkValue("b2b.packetCount", packetCount, expectedCount());
    checkValue("b2b.abortFlag", abortFlag, 0);

    // collectData (and maybe fx3_ready) drops after read 10; the packet still completes
    clearLog();
    collectData = 1'b1; dataAvailable = 1'b1; fx3_ready = 1'b1;
    waitReads("stop", 10, 100);
    collectData = 1'b0;
    fx3_ready = 1'($urandom_range(0, 1));
    waitIdle("stop", PW + 100);
    tick(20);
    expPackets++;
    checkLog("stop", PW, 0, 0);
    checkValue("stop.packetCount", packetCount, expectedCount());
    checkValue("stop.busy", busy, 0);
    dataAvailable = 1'b0; fx3_ready = 1'b1;

    // Aborts: the directed case after read 100, then random abort points
    runAbort(100);
    for (int i = 0; i < 4; i++) runAbort($urandom_range(2, 300));

    // Start condition sampled with bufferError high: straight to HALT, no pktend
    clearLog();
    collectData = 1'b1; dataAvailable = 1'b1; fx3_ready = 1'b1; bufferError = 1'b1;
    tick(3);
    checkValue("idleErr.abortFlag", abortFlag, 1);
    checkValue("idleErr.busy", busy, 1);
    checkValue("idleErr.reads", readLog.size(), 0);
    checkValue("idleErr.pktend", pktendLog.size(), 0);
    collectData = 1'b0; bufferError = 1'b0;
    tick(3);
    checkValue("idleErr.flagCleared", abortFlag, 0);
    checkValue("idleErr.idle", busy, 0);

    // Reset in the middle of read 500: outputs return at once, without a drain
    clearLog();
    collectData = 1'b1; dataAvailable = 1'b1; fx3_ready = 1'b1;
    waitReads("midRst", 499, 600);
    #2;
    nReset = 1'b0;
    #1;
    expPackets = 0;
    checkValue("midRst.readData", readData, 0);
    checkValue("midRst.wr_n", fx3_wr_n, 1);
    checkValue("midRst.pktend_n", fx3_pktend_n, 1);
    checkValue("midRst.busy", busy, 0);
    checkValue("midRst.packetCount", packetCount, 0);
    tick(2);
    clearLog();
    nReset = 1'b1;

    // Fresh burst after reset; bufferError on the last read still completes the packet
    waitReads("fresh", PW - 1, PW + 100);
    bufferError = 1'b1;
    tick(1);
    bufferError = 1'b0;
    dataAvailable = 1'b0;
    waitIdle("fresh", 100);
    tick(5);
    expPackets++;
    checkLog("fresh", PW, 0, 0);
    checkValue("fresh.abortFlag", abortFlag, 0);
    checkValue("fresh.packetCount", packetCount, expectedCount());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
